// File: rtl/pmod_enc_decoder.sv
// PmodENC front-end: synchronizes and debounces the raw Pmod pins, decodes
// A/B quadrature (x4) into a signed position counter with direction, step
// and error pulses, and produces button/switch levels and a press event.
module pmod_enc_decoder #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 s00_axi_aclk,
    input  logic                 s00_axi_aresetn,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic                 enc_btn,
    input  logic                 enc_swt,
    input  logic                 pos_clr,
    input  logic                 pos_load,
    input  logic [CNT_WIDTH-1:0] pos_load_val,
    output logic [CNT_WIDTH-1:0] position,
    output logic                 dir,
    output logic                 step_pulse,
    output logic                 err_pulse,
    output logic                 btn_level,
    output logic                 btn_press_pulse,
    output logic                 swt_level
);

    localparam int N_IN = 4;
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Input bit order used throughout: 3 = A, 2 = B, 1 = BTN, 0 = SWT.
    localparam int IDX_A   = 3;
    localparam int IDX_B   = 2;
    localparam int IDX_BTN = 1;
    localparam int IDX_SWT = 0;

    logic [N_IN-1:0] raw;
    logic [N_IN-1:0] sync_pipe [SYNC_STAGES];
    logic [N_IN-1:0] sync;
    logic [N_IN-1:0] deb;
    logic [DB_W-1:0] db_cnt [N_IN];

    logic [1:0] cur_ab;
    logic [1:0] prev_ab;
    logic [1:0] cur_ph;
    logic [1:0] prev_ph;
    logic [1:0] ph_delta;
    logic       step_fwd;
    logic       step_rev;
    logic       step_err;
    logic       btn_prev;

    // Map Gray-coded AB onto a 0..3 phase along the forward sequence
    // 00 -> 10 -> 11 -> 01, so a step is just a +/-1 phase difference.
    function automatic logic [1:0] ab_phase(input logic [1:0] ab);
        return {ab[0], ab[1] ^ ab[0]};
    endfunction

    assign raw  = {enc_a, enc_b, enc_btn, enc_swt};
    assign sync = sync_pipe[SYNC_STAGES-1];

    // Multi-stage synchronizer for all four asynchronous pins.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            // NOTE: this array is a handful of flops, not a RAM, so every
            // stage is reset; non-blocking assignments keep the shift ordered.
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_pipe[i] <= '0;
            end
        end else begin
            sync_pipe[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_pipe[i] <= sync_pipe[i-1];
            end
        end
    end

    // Per-input debounce: a differing value must persist DEBOUNCE_CYCLES clocks.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            deb <= '0;
            for (int i = 0; i < N_IN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (sync[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign cur_ab   = {deb[IDX_A], deb[IDX_B]};
    assign cur_ph   = ab_phase(cur_ab);
    assign prev_ph  = ab_phase(prev_ab);
    assign ph_delta = cur_ph - prev_ph;

    // Classify the AB transition by phase difference: +1 fwd, -1 rev, 2 illegal.
    always_comb begin
        // NOTE: defaults first so every path assigns each output (no latch).
        step_fwd = 1'b0;
        step_rev = 1'b0;
        step_err = 1'b0;
        case (ph_delta)
            2'd1:    step_fwd = 1'b1;
            2'd2:    step_err = 1'b1;
            2'd3:    step_rev = 1'b1;
            default: ;
        endcase
    end

    // Registered decode outputs; clr beats load beats step for position only.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            prev_ab    <= '0;
            position   <= '0;
            dir        <= 1'b0;
            step_pulse <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            prev_ab    <= cur_ab;
            step_pulse <= step_fwd | step_rev;
            err_pulse  <= step_err;
            if (step_fwd | step_rev) begin
                dir <= step_fwd;
            end
            if (pos_clr) begin
                position <= '0;
            end else if (pos_load) begin
                position <= pos_load_val;
            end else if (step_fwd) begin
                position <= position + CNT_WIDTH'(1);
            end else if (step_rev) begin
                position <= position - CNT_WIDTH'(1);
            end
        end
    end

    // Button rising-edge detector on the debounced level.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            btn_prev        <= 1'b0;
            btn_press_pulse <= 1'b0;
        end else begin
            btn_prev        <= deb[IDX_BTN];
            btn_press_pulse <= deb[IDX_BTN] & ~btn_prev;
        end
    end

    assign btn_level = deb[IDX_BTN];
    assign swt_level = deb[IDX_SWT];

endmodule

// File: tb/tb_pmod_enc_decoder.sv
// Self-checking bench for pmod_enc_decoder: a table of quadrature steps,
// hand-written corner sequences (glitch, illegal jump, clr/load priority,
// button bounce, reset mid-debounce) and a randomized run against a
// sequence-lookup reference model.
`timescale 1ns/1ps
module tb_pmod_enc_decoder;

    localparam int SS = 2;
    localparam int DC = 4;
    localparam int CW = 16;
    localparam int LAT = SS + DC + 1;

    logic          clk          = 1'b0;
    logic          rst_n        = 1'b0;
    logic          enc_a        = 1'b0;
    logic          enc_b        = 1'b0;
    logic          enc_btn      = 1'b0;
    logic          enc_swt      = 1'b0;
    logic          pos_clr      = 1'b0;
    logic          pos_load     = 1'b0;
    logic [CW-1:0] pos_load_val = '0;
    logic [CW-1:0] position;
    logic          dir;
    logic          step_pulse;
    logic          err_pulse;
    logic          btn_level;
    logic          btn_press_pulse;
    logic          swt_level;

    int checks     = 0;
    int failures   = 0;
    int step_seen  = 0;
    int err_seen   = 0;
    int press_seen = 0;

    typedef struct {
        bit            do_load;
        logic [CW-1:0] load_val;
        logic [1:0]    ab;
        logic [CW-1:0] exp_pos;
        logic          exp_dir;
    } vec_t;

    vec_t vecs [11];

    pmod_enc_decoder #(
        .SYNC_STAGES(SS),
        .DEBOUNCE_CYCLES(DC),
        .CNT_WIDTH(CW)
    ) dut (
        .s00_axi_aclk(clk),
        .s00_axi_aresetn(rst_n),
        .enc_a(enc_a),
        .enc_b(enc_b),
        .enc_btn(enc_btn),
        .enc_swt(enc_swt),
        .pos_clr(pos_clr),
        .pos_load(pos_load),
        .pos_load_val(pos_load_val),
        .position(position),
        .dir(dir),
        .step_pulse(step_pulse),
        .err_pulse(err_pulse),
        .btn_level(btn_level),
        .btn_press_pulse(btn_press_pulse),
        .swt_level(swt_level)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Pulse counters, sampled on the inactive edge.
    always @(negedge clk) begin
        if (step_pulse)      step_seen++;
        if (err_pulse)       err_seen++;
        if (btn_press_pulse) press_seen++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [CW-1:0] val);
        pos_load_val = val;
        pos_load     = 1'b1;
        tick(1);
        pos_load     = 1'b0;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({position, dir, step_pulse, err_pulse, btn_level, btn_press_pulse, swt_level});
    endfunction

    // Next AB value along the forward sequence 00 -> 10 -> 11 -> 01 -> 00.
    function automatic logic [1:0] fwd_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    initial begin
        int            s0;
        int            e0;
        int            p0;
        int            lat;
        int            lvl_k;
        int            prs_k;
        logic [1:0]    m_ab;
        logic [1:0]    nab;
        logic [1:0]    g;
        logic [CW-1:0] m_pos;
        logic [CW-1:0] lv;
        logic          m_dir;
        int            m_steps;
        int            m_errs;

        vecs[0]  = '{1'b0, 16'h0000, 2'b10, 16'h0001, 1'b1};
        vecs[1]  = '{1'b0, 16'h0000, 2'b11, 16'h0002, 1'b1};
        vecs[2]  = '{1'b0, 16'h0000, 2'b01, 16'h0003, 1'b1};
        vecs[3]  = '{1'b0, 16'h0000, 2'b00, 16'h0004, 1'b1};
        vecs[4]  = '{1'b1, 16'h0002, 2'b01, 16'h0001, 1'b0};
        vecs[5]  = '{1'b0, 16'h0000, 2'b11, 16'h0000, 1'b0};
        vecs[6]  = '{1'b0, 16'h0000, 2'b10, 16'hFFFF, 1'b0};
        vecs[7]  = '{1'b0, 16'h0000, 2'b00, 16'hFFFE, 1'b0};
        vecs[8]  = '{1'b0, 16'h0000, 2'b01, 16'hFFFD, 1'b0};
        vecs[9]  = '{1'b1, 16'h7FFF, 2'b00, 16'h8000, 1'b1};
        vecs[10] = '{1'b0, 16'h0000, 2'b01, 16'h7FFF, 1'b0};

        // Reset held while pins toggle: everything stays 0.
        for (int i = 0; i < 10; i++) begin
            {enc_a, enc_b, enc_btn, enc_swt} = 4'($urandom);
            tick(1);
        end
        check("outs_in_reset", all_outs(), 32'h0);
        {enc_a, enc_b, enc_btn, enc_swt} = 4'b0000;
        tick(2);
        rst_n = 1'b1;
        tick(10);
        check("outs_after_release", all_outs(), 32'h0);

        // Table-driven single steps, each held 8 clocks.
        for (int r = 0; r < 11; r++) begin
            if (vecs[r].do_load) load(vecs[r].load_val);
            s0  = step_seen;
            e0  = err_seen;
            lat = -1;
            {enc_a, enc_b} = vecs[r].ab;
            for (int k = 1; k <= 8; k++) begin
                tick(1);
                if (step_pulse && lat < 0) lat = k;
            end
            check($sformatf("vec%0d_pos", r), 32'(position), 32'(vecs[r].exp_pos));
            check($sformatf("vec%0d_dir", r), 32'(dir), 32'(vecs[r].exp_dir));
            check($sformatf("vec%0d_steps", r), step_seen - s0, 1);
            check($sformatf("vec%0d_errs", r), err_seen - e0, 0);
            check($sformatf("vec%0d_latency", r), lat, LAT);
        end

        // Forward to 00, then a 3-clock glitch on A must not propagate.
        {enc_a, enc_b} = 2'b00;
        tick(10);
        check("pre_glitch_pos", 32'(position), 32'h8000);
        s0 = step_seen;
        e0 = err_seen;
        enc_a = 1'b1;
        tick(3);
        enc_a = 1'b0;
        tick(12);
        check("glitch_steps", step_seen - s0, 0);
        check("glitch_errs", err_seen - e0, 0);
        check("glitch_pos", 32'(position), 32'h8000);

        // Illegal 00 -> 11 jump: one error, no count, dir kept.
        {enc_a, enc_b} = 2'b11;
        tick(10);
        check("jump_errs", err_seen - e0, 1);
        check("jump_steps", step_seen - s0, 0);
        check("jump_pos", 32'(position), 32'h8000);
        check("jump_dir", 32'(dir), 32'h1);

        // pos_clr coincident with a forward step from position 5.
        load(16'd5);
        {enc_a, enc_b} = 2'b01;
        tick(LAT - 1);
        pos_clr = 1'b1;
        tick(1);
        pos_clr = 1'b0;
        check("clr_step_pulse", 32'(step_pulse), 32'h1);
        check("clr_step_pos", 32'(position), 32'h0);
        check("clr_step_dir", 32'(dir), 32'h1);
        tick(3);

        // pos_load coincident with a reverse step: load wins, dir follows step.
        {enc_a, enc_b} = 2'b11;
        tick(LAT - 1);
        pos_load_val = 16'h0100;
        pos_load     = 1'b1;
        tick(1);
        pos_load     = 1'b0;
        check("load_step_pulse", 32'(step_pulse), 32'h1);
        check("load_step_pos", 32'(position), 32'h0100);
        check("load_step_dir", 32'(dir), 32'h0);
        tick(3);

        // pos_clr and pos_load together: clear wins.
        pos_load_val = 16'h1234;
        pos_load     = 1'b1;
        pos_clr      = 1'b1;
        tick(1);
        pos_load     = 1'b0;
        pos_clr      = 1'b0;
        check("clr_and_load", 32'(position), 32'h0);

        // Button bounce every 2 clocks, then settle high.
        p0 = press_seen;
        for (int i = 0; i < 8; i++) begin
            enc_btn = ~enc_btn;
            tick(2);
        end
        check("bounce_level", 32'(btn_level), 32'h0);
        enc_btn = 1'b1;
        lvl_k = -1;
        prs_k = -1;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (btn_level && lvl_k < 0) lvl_k = k;
            if (btn_press_pulse && prs_k < 0) prs_k = k;
        end
        check("press_count", press_seen - p0, 1);
        check("btn_level_high", 32'(btn_level), 32'h1);
        check("press_after_level", prs_k - lvl_k, 1);
        enc_btn = 1'b0;
        tick(10);
        check("no_press_on_release", press_seen - p0, 1);
        check("btn_level_low", 32'(btn_level), 32'h0);
        enc_swt = 1'b1;
        tick(8);
        check("swt_level", 32'(swt_level), 32'h1);

        // Reset mid-debounce: outputs clear at once, count restarts afterwards.
        load(16'h00AA);
        enc_btn = 1'b1;
        tick(4);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", all_outs(), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(SS + DC - 1);
        check("debounce_restart_early", 32'(btn_level), 32'h0);
        tick(1);
        check("debounce_restart_done", 32'(btn_level), 32'h1);
        check("pos_after_reset", 32'(position), 32'h0);

        // Power-up with A=B=1: a single error, no count.
        rst_n = 1'b0;
        enc_btn = 1'b0;
        {enc_a, enc_b} = 2'b11;
        tick(2);
        s0 = step_seen;
        e0 = err_seen;
        rst_n = 1'b1;
        tick(12);
        check("powerup_errs", err_seen - e0, 1);
        check("powerup_steps", step_seen - s0, 0);
        check("powerup_pos", 32'(position), 32'h0);

        // Randomized moves, glitches, clears and loads against the model.
        m_ab    = 2'b11;
        m_pos   = '0;
        m_dir   = 1'b0;
        m_steps = 0;
        m_errs  = 0;
        s0 = step_seen;
        e0 = err_seen;
        for (int it = 0; it < 60; it++) begin
            nab = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                g = m_ab ^ 2'($urandom_range(1, 3));
                {enc_a, enc_b} = g;
                tick($urandom_range(1, DC - 1));
                {enc_a, enc_b} = m_ab;
                tick(3);
            end
            case ($urandom_range(0, 7))
                0: begin
                    lv = 16'($urandom);
                    load(lv);
                    m_pos = lv;
                end
                1: begin
                    pos_clr = 1'b1;
                    tick(1);
                    pos_clr = 1'b0;
                    m_pos = '0;
                end
                default: ;
            endcase
            {enc_a, enc_b} = nab;
            tick(10);
            if (nab != m_ab) begin
                if (nab == fwd_of(m_ab)) begin
                    m_pos = m_pos + 16'd1;
                    m_dir = 1'b1;
                    m_steps++;
                end else if (m_ab == fwd_of(nab)) begin
                    m_pos = m_pos - 16'd1;
                    m_dir = 1'b0;
                    m_steps++;
                end else begin
                    m_errs++;
                end
            end
            m_ab = nab;
            check($sformatf("rnd%0d_pos", it), 32'(position), 32'(m_pos));
            check($sformatf("rnd%0d_dir", it), 32'(dir), 32'(m_dir));
            check($sformatf("rnd%0d_steps", it), step_seen - s0, m_steps);
            check($sformatf("rnd%0d_errs", it), err_seen - e0, m_errs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pmod_enc_decoder.md
Name: pmod_enc_decoder

Overview:
Front-end for the PmodENC peripheral. It sits directly upstream of the AXI4-Lite register slave. It synchronizes and debounces the raw Pmod pins (A, B, BTN, SWT) and decodes A/B quadrature (x4) into a signed position counter, direction, step and error pulses. It also produces button/switch levels and press events, which the register slave exposes as read registers.

Parameters:
SYNC_STAGES, 2, flip-flop stages per input synchronizer (minimum 2)
DEBOUNCE_CYCLES, 1000, consecutive stable clocks needed before a debounced value updates (minimum 1)
CNT_WIDTH, 16, width of the position counter (two's complement)

Ports:
s00_axi_aclk  in  1  sole clock
s00_axi_aresetn  in  1  asynchronous active-low reset
enc_a  in  1  raw encoder channel A (asynchronous)
enc_b  in  1  raw encoder channel B (asynchronous)
enc_btn  in  1  raw push button (asynchronous)
enc_swt  in  1  raw slide switch (asynchronous)
pos_clr  in  1  one-cycle pulse from register slave; zero the position
pos_load  in  1  one-cycle pulse; load pos_load_val
pos_load_val  in  CNT_WIDTH  value loaded on pos_load
position  out  CNT_WIDTH  signed position count
dir  out  1  direction of last valid step: 1 = +1, 0 = -1
step_pulse  out  1  one-cycle pulse per valid step
err_pulse  out  1  one-cycle pulse on an illegal A/B transition
btn_level  out  1  debounced button
btn_press_pulse  out  1  one-cycle pulse on debounced button 0->1
swt_level  out  1  debounced switch

Behaviour:
- Reset: async assert clears all sync flops, debounce counters, debounced values, the previous-AB register, position, and every output to 0. Outputs remain 0 while reset is held.
- Reset mid-operation: any in-progress debounce count is discarded. After release, all decoding restarts from debounced = 0.
- Synchronizer: SYNC_STAGES flops per input, reset to 0.
- Debounce, per input, with a counter of width clog2(DEBOUNCE_CYCLES)+1:
  - sync == debounced: counter cleared.
  - sync != debounced: counter increments. When it reaches DEBOUNCE_CYCLES-1 and sync still differs, debounced takes sync and the counter clears.
  - Net effect: a change stable for DEBOUNCE_CYCLES clocks appears on debounced exactly DEBOUNCE_CYCLES clocks after it leaves the synchronizer.
  - A glitch shorter than DEBOUNCE_CYCLES never propagates.
- Quadrature decode compares the registered previous AB = {A,B} against the current debounced AB each clock:
  - Forward sequence 00->10->11->01->00: +1, dir<=1, step_pulse=1.
  - Reverse sequence 00->01->11->10->00: -1, dir<=0, step_pulse=1.
  - No change: nothing.
  - Both bits changed (00<->11, 10<->01): err_pulse=1, position and dir unchanged.
  - The previous-AB register always updates to the current value.
- Latency: raw pin edge to position/step_pulse = SYNC_STAGES + DEBOUNCE_CYCLES + 1 clocks.
- Position arithmetic is modulo 2^CNT_WIDTH with silent wrap. Examples: 0x7FFF +1 -> 0x8000; 0x0000 -1 -> 0xFFFF. There is no saturation and no overflow flag.
- Same-cycle priority: pos_clr > pos_load > step.
  - A step coinciding with clr or load is discarded from position.
  - step_pulse and dir still reflect that step.
  - pos_clr and pos_load asserted together: clr wins.
- position, dir and all pulses are registered outputs.
- btn_press_pulse: asserts one clock after debounced btn rises, lasts one clock. No pulse on release.
- btn_level and swt_level equal the debounced values.
- Power-up artifact: if A=B=1 at reset release, the first debounced transition 00->11 yields a single err_pulse and no count. This is the specified behaviour.

Test Plan (all scenarios use DEBOUNCE_CYCLES=4, SYNC_STAGES=2, CNT_WIDTH=16):
1. Reset held, pins toggling -> all outputs 0. Release with AB=00, then drive forward sequence 10,11,01,00, each held 8 clocks -> position=4, four step_pulses, dir=1, first pulse 7 clocks after the pin edge.
2. From position=2, drive reverse sequence 01,11,10,00,01 -> position 0xFFFD, dir=0, no err_pulse.
3. pos_load with pos_load_val=0x7FFF, then one forward step -> position=0x8000. Then one reverse step -> 0x7FFF.
4. 3-clock glitch on enc_a -> no change to position, step_pulse or err_pulse. Then jump AB 00->11 in one edge -> one err_pulse, position unchanged.
5. pos_clr coincident with a forward step while position=5 -> position=0, step_pulse=1, dir=1. Also pos_clr and pos_load together -> 0.
6. enc_btn bounces 1/0 every 2 clocks, then settles high -> exactly one btn_press_pulse and btn_level=1. Assert reset mid-debounce -> all outputs 0 immediately.
